// File: rtl/async_fifo_pkg.sv
// Shared constants for the async FIFO read-side logic.
// Defines the prefetch depth and the width of its occupancy count.
package async_fifo_pkg;
    localparam int BUF_DEPTH = 2;
    localparam int LVL_W     = $clog2(BUF_DEPTH + 1);
    typedef logic [LVL_W-1:0] lvl_t;
endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry circular prefetch store with its occupancy. The head is a dedicated register.
// Latency 1 cycle from write to head. No backpressure here: the caller never writes when full.
module fifo_rd_skid
    import async_fifo_pkg::*;
#(
    parameter int DATASIZE = 8
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic                wr_en,
    input  logic                rd_en,
    input  logic                flush,
    input  logic [DATASIZE-1:0] wdata,
    output lvl_t                level,
    output logic [DATASIZE-1:0] head_dat
);
    logic [DATASIZE-1:0] mem_q [BUF_DEPTH];
    logic [DATASIZE-1:0] mem_d [BUF_DEPTH];
    logic                wr_idx_q, wr_idx_d;
    logic                rd_idx_q, rd_idx_d;
    lvl_t                level_q, level_d;
    logic [DATASIZE-1:0] head_q, head_d;

    always_comb begin
        mem_d    = mem_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        level_d  = level_q;
        if (flush) begin
            wr_idx_d = 1'b0;
            rd_idx_d = 1'b0;
            level_d  = '0;
        end else begin
            if (wr_en) begin
                mem_d[wr_idx_q] = wdata;
                wr_idx_d        = ~wr_idx_q;
            end
            if (rd_en) begin
                rd_idx_d = ~rd_idx_q;
            end
            level_d = level_q + lvl_t'(wr_en) - lvl_t'(rd_en);
        end
        // An empty buffer keeps the last presented word so the output never shows stale slots.
        head_d = (level_d != '0) ? mem_d[rd_idx_d] : head_q;
    end

    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_idx_q <= 1'b0;
            rd_idx_q <= 1'b0;
            level_q  <= '0;
            head_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            level_q  <= level_d;
            head_q   <= head_d;
        end
    end

    assign level    = level_q;
    assign head_dat = head_q;
endmodule

// File: rtl/fifo_rd_stream.sv
// Pops the async FIFO read side into a registered valid/ready stream with a delivered-word count.
// Latency 1 cycle from rinc to m_valid; with m_ready low it prefetches two words, then stops popping.
module fifo_rd_stream
    import async_fifo_pkg::*;
#(
    parameter int DATASIZE = 8,
    parameter int CNTSIZE  = 16
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic                rempty,
    input  logic [DATASIZE-1:0] rdata,
    output logic                rinc,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [DATASIZE-1:0] m_data,
    input  logic                flush,
    output logic [LVL_W-1:0]    buf_level,
    output logic [CNTSIZE-1:0]  word_cnt
);
    logic               fire;
    logic               pop;
    lvl_t               level;
    logic [CNTSIZE-1:0] word_cnt_q, word_cnt_d;

    // A full buffer may still pop when the head leaves in the same cycle.
    always_comb begin
        fire       = m_valid & m_ready;
        pop        = ~rempty & ~flush & rrst & ((level < lvl_t'(BUF_DEPTH)) | fire);
        word_cnt_d = word_cnt_q + CNTSIZE'(fire);
    end

    fifo_rd_skid #(
        .DATASIZE (DATASIZE)
    ) u_skid (
        .rclk     (rclk),
        .rrst     (rrst),
        .wr_en    (pop),
        .rd_en    (fire),
        .flush    (flush),
        .wdata    (rdata),
        .level    (level),
        .head_dat (m_data)
    );

    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            word_cnt_q <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
        end
    end

    assign rinc      = pop;
    assign m_valid   = (level != '0);
    assign buf_level = level;
    assign word_cnt  = word_cnt_q;
endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;
    logic        rclk = 1'b0;
    logic        rrst;
    logic        rempty;
    logic [7:0]  rdata;
    logic        rinc;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        flush;
    logic [1:0]  buf_level;
    logic [15:0] word_cnt;
    logic        rinc4, m_valid4;
    logic [7:0]  m_data4;
    logic [1:0]  buf_level4;
    logic [3:0]  word_cnt4;

    fifo_rd_stream #(.DATASIZE(8), .CNTSIZE(16)) dut (
        .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rinc(rinc),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .flush(flush),
        .buf_level(buf_level), .word_cnt(word_cnt)
    );

    fifo_rd_stream #(.DATASIZE(8), .CNTSIZE(4)) dut4 (
        .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rinc(rinc4),
        .m_valid(m_valid4), .m_ready(m_ready), .m_data(m_data4), .flush(flush),
        .buf_level(buf_level4), .word_cnt(word_cnt4)
    );

    always #5 rclk = ~rclk;

    // Environment and reference model
    logic [7:0] fifo_q[$];
    logic [7:0] mbuf[$];
    logic [7:0] last_d;
    int         cnt;
    int         rinc_cnt;
    int         n_cmp;
    int         n_bad;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic upd_fifo();
        rempty = (fifo_q.size() == 0);
        rdata  = rempty ? 8'hEE : fifo_q[0];
    endtask

    task automatic model_reset();
        mbuf.delete();
        cnt    = 0;
        last_d = 8'h00;
    endtask

    // One clock: called just after a rising edge with inputs already set.
    task automatic cyc();
        bit         ex_fire, ex_pop, rinc_s;
        logic [7:0] w;
        upd_fifo();
        ex_fire = rrst && (mbuf.size() != 0) && m_ready;
        ex_pop  = rrst && (fifo_q.size() != 0) && !flush && ((mbuf.size() < 2) || ex_fire);
        @(negedge rclk);
        chk("rinc", rinc, ex_pop);
        chk("m_valid", m_valid, mbuf.size() != 0);
        chk("buf_level", buf_level, mbuf.size());
        chk("m_data", m_data, last_d);
        chk("word_cnt", word_cnt, cnt % 65536);
        chk("word_cnt4", word_cnt4, cnt % 16);
        rinc_s = rinc;
        w = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
        @(posedge rclk);
        if (!rrst) begin
            model_reset();
        end else begin
            if (rinc_s) begin
                rinc_cnt++;
                if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            end
            if (ex_fire) begin
                void'(mbuf.pop_front());
                cnt++;
            end
            if (flush) mbuf.delete();
            else if (ex_pop) mbuf.push_back(w);
            if (mbuf.size() != 0) last_d = mbuf[0];
        end
        #1;
    endtask

    initial begin
        int pushed, base;
        n_cmp = 0; n_bad = 0; rinc_cnt = 0;
        model_reset();

        // 1: asynchronous reset with a word waiting in the FIFO
        rrst = 1'b0; m_ready = 1'b0; flush = 1'b0;
        fifo_q.push_back(8'h99);
        upd_fifo();
        #1;
        chk("rst_rinc", rinc, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_buf_level", buf_level, 0);
        chk("rst_word_cnt", word_cnt, 0);
        chk("rst_m_data", m_data, 0);
        @(posedge rclk); #1;
        repeat (2) cyc();
        rrst = 1'b1;
        #1;
        chk("release_rinc", rinc, 1);
        cyc();
        chk("first_word", m_data, 8'h99);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("flush_drop", buf_level, 0);

        // 2: streaming 0x10..0x1F with the consumer always ready
        for (int i = 0; i < 16; i++) fifo_q.push_back(8'h10 + 8'(i));
        m_ready = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            cyc();
            if (k <= 16) begin
                chk("stream_data", m_data, 8'h10 + 8'(k - 1));
                chk("stream_valid", m_valid, 1);
            end
            if (k == 16) chk("wrap_15", word_cnt4, 15);
        end
        chk("stream_idle", m_valid, 0);
        chk("stream_cnt", word_cnt, 16);
        chk("wrap_0", word_cnt4, 0);

        // 3: backpressure then release
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) fifo_q.push_back(8'hA0 + 8'(i));
        rinc_cnt = 0;
        repeat (5) cyc();
        chk("bp_pops", rinc_cnt, 2);
        chk("bp_level", buf_level, 2);
        chk("bp_hold", m_data, 8'hA0);
        m_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cyc();
            if (i == 1) chk("wrap_1", word_cnt4, 1);
            chk("bp_data", m_data, 8'hA0 + 8'(i));
            chk("bp_valid", m_valid, 1);
        end
        cyc();
        chk("bp_idle", m_valid, 0);
        chk("bp_cnt", word_cnt, 20);

        // 4: flush with two words buffered and one still in the FIFO
        m_ready = 1'b0;
        fifo_q.push_back(8'h55); fifo_q.push_back(8'h66); fifo_q.push_back(8'h77);
        repeat (2) cyc();
        chk("fl_level", buf_level, 2);
        chk("fl_head", m_data, 8'h55);
        flush = 1'b1; m_ready = 1'b1;
        #1;
        chk("fl_no_rinc", rinc, 0);
        cyc();
        flush = 1'b0;
        chk("fl_cnt", word_cnt, 21);
        chk("fl_level0", buf_level, 0);
        cyc();
        chk("fl_next", m_data, 8'h77);
        chk("fl_next_valid", m_valid, 1);
        cyc();

        // 5: random producer timing and random consumer stalls
        pushed = 0;
        base = cnt;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) != 0) begin
                fifo_q.push_back(8'(pushed * 7 + 3));
                pushed++;
            end
            m_ready = ($urandom_range(0, 2) != 0);
            cyc();
        end
        m_ready = 1'b1;
        repeat (pushed + 5) begin
            cyc();
            if (fifo_q.size() == 0 && mbuf.size() == 0) break;
        end
        chk("rand_delivered", cnt - base, pushed);
        chk("rand_drained", m_valid, 0);

        // Reset in the middle of traffic
        m_ready = 1'b0;
        fifo_q.push_back(8'hC1); fifo_q.push_back(8'hC2); fifo_q.push_back(8'hC3);
        repeat (3) cyc();
        rrst = 1'b0;
        fifo_q.delete();
        model_reset();
        upd_fifo();
        #1;
        chk("mid_rst_valid", m_valid, 0);
        chk("mid_rst_level", buf_level, 0);
        chk("mid_rst_cnt", word_cnt, 0);
        chk("mid_rst_rinc", rinc, 0);
        repeat (2) cyc();
        rrst = 1'b1;
        fifo_q.push_back(8'hD0);
        m_ready = 1'b1;
        repeat (3) cyc();
        chk("post_rst_cnt", word_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
